// File: rtl/fft_power_averager.sv
// fft_power_averager: averages (re^2+im^2)/2 per bin over 2^AVG_COUNT_LOG frames, then streams the spectrum
// Ports: aclk/aresetn (async active-low); S_AXIS_fft_* complex bins in ({im,re}, signed);
// M_AXIS_power_* averaged unsigned power out, tlast on bin N-1; frame_error sticky misaligned-tlast flag.
module fft_power_averager #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int FFT_LENGTH_LOG   = 8,
  parameter int AVG_COUNT_LOG    = 2
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [2*AXIS_TDATA_WIDTH-1:0] S_AXIS_fft_tdata,
  input  logic                          S_AXIS_fft_tvalid,
  output logic                          S_AXIS_fft_tready,
  input  logic                          S_AXIS_fft_tlast,
  output logic [2*AXIS_TDATA_WIDTH-1:0] M_AXIS_power_tdata,
  output logic                          M_AXIS_power_tvalid,
  input  logic                          M_AXIS_power_tready,
  output logic                          M_AXIS_power_tlast,
  output logic                          frame_error
);
  localparam int W = AXIS_TDATA_WIDTH;
  localparam int DW = 2 * W;
  localparam int NL = FFT_LENGTH_LOG;
  localparam int AL = AVG_COUNT_LOG;
  localparam int AW = DW + AL;
  localparam int FW = AL + 1;
  localparam logic [FW-1:0] LAST_FRM = FW'((1 << AL) - 1);
  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;
  logic ready_q, ready_d, err_q, err_d;
  logic [NL-1:0] bin_q, bin_d, a1_q, a1_d;
  logic [FW-1:0] frm_q, frm_d;
  logic v1_q, v1_d, ow1_q, ow1_d;
  logic [DW-1:0] sqr_q, sqr_d, sqi_q, sqi_d;
  logic [NL:0] rc_q, rc_d;
  logic rv_q, rv_d, rl_q, rl_d;
  logic ov_q, ov_d, ol_q, ol_d, sv_q, sv_d, sl_q, sl_d;
  logic [DW-1:0] od_q, od_d, sd_q, sd_d;
  logic [AW-1:0] ram [1<<NL];
  logic [AW-1:0] dr_q;
  logic signed [W-1:0] re, im;
  logic signed [DW-1:0] rex, imx;
  logic [DW:0] psum;
  logic [AW-1:0] wr_data;
  logic [NL-1:0] rd_addr;
  logic [DW-1:0] arr;
  logic [1:0] occ;
  logic xfer, pop, issue;
  assign re = S_AXIS_fft_tdata[W-1:0];
  assign im = S_AXIS_fft_tdata[DW-1:W];
  assign rex = DW'(re);
  assign imx = DW'(im);
  assign psum = {1'b0, sqr_q} + {1'b0, sqi_q};
  assign wr_data = ow1_q ? AW'(psum[DW:1]) : dr_q + AW'(psum[DW:1]);
  assign arr = dr_q[AW-1:AL];
  assign rd_addr = state_q == DRAIN ? rc_q[NL-1:0] : bin_q;
  assign xfer = S_AXIS_fft_tvalid && ready_q;
  assign pop = ov_q && M_AXIS_power_tready;
  assign occ = 2'(ov_q) + 2'(sv_q) + 2'(rv_q);
  // A read is issued only if its data is guaranteed a slot in the output register or skid buffer.
  assign issue = state_q == DRAIN && !rc_q[NL] && occ - 2'(pop) < 2'd2;
  assign S_AXIS_fft_tready = ready_q;
  assign M_AXIS_power_tdata = od_q;
  assign M_AXIS_power_tvalid = ov_q;
  assign M_AXIS_power_tlast = ol_q;
  assign frame_error = err_q;
  // The read port is shared: stage-1 reads in ACCUM, drain reads in DRAIN; frame 0 overwrites, so no clear.
  always_ff @(posedge aclk) begin
    if (v1_q) ram[a1_q] <= wr_data;
    dr_q <= ram[rd_addr];
  end
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    frm_d = frm_q;
    err_d = err_q;
    v1_d = xfer;
    a1_d = bin_q;
    ow1_d = frm_q == '0;
    sqr_d = rex * rex;
    sqi_d = imx * imx;
    rc_d = state_q == DRAIN ? rc_q + (NL+1)'(issue) : '0;
    rv_d = issue;
    rl_d = issue && rc_q[NL-1:0] == '1;
    ov_d = ov_q;
    od_d = od_q;
    ol_d = ol_q;
    sv_d = sv_q;
    sd_d = rv_q ? arr : sd_q;
    sl_d = rv_q ? rl_q : sl_q;
    if (!ov_q || pop) begin
      ov_d = sv_q || rv_q;
      od_d = sv_q ? sd_q : rv_q ? arr : od_q;
      ol_d = sv_q ? sl_q : rv_q && rl_q;
      sv_d = sv_q && rv_q;
    end else if (rv_q) begin
      sv_d = 1'b1;
    end
    if (xfer) begin
      if (S_AXIS_fft_tlast && bin_q == '1) begin
        bin_d = '0;
        frm_d = frm_q == LAST_FRM ? '0 : frm_q + 1'b1;
        state_d = frm_q == LAST_FRM ? FLUSH : ACCUM;
      end else if (S_AXIS_fft_tlast || bin_q == '1) begin
        err_d = 1'b1;
        bin_d = '0;
        frm_d = '0;
      end else begin
        bin_d = bin_q + 1'b1;
      end
    end
    if (state_q == FLUSH && !v1_q) state_d = DRAIN;
    if (pop && ol_q) begin
      state_d = ACCUM;
      frm_d = '0;
    end
    ready_d = state_d == ACCUM;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ACCUM;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      bin_q <= '0;
      frm_q <= '0;
      v1_q <= 1'b0;
      a1_q <= '0;
      ow1_q <= 1'b0;
      sqr_q <= '0;
      sqi_q <= '0;
      rc_q <= '0;
      rv_q <= 1'b0;
      rl_q <= 1'b0;
      ov_q <= 1'b0;
      od_q <= '0;
      ol_q <= 1'b0;
      sv_q <= 1'b0;
      sd_q <= '0;
      sl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q <= err_d;
      bin_q <= bin_d;
      frm_q <= frm_d;
      v1_q <= v1_d;
      a1_q <= a1_d;
      ow1_q <= ow1_d;
      sqr_q <= sqr_d;
      sqi_q <= sqi_d;
      rc_q <= rc_d;
      rv_q <= rv_d;
      rl_q <= rl_d;
      ov_q <= ov_d;
      od_q <= od_d;
      ol_q <= ol_d;
      sv_q <= sv_d;
      sd_q <= sd_d;
      sl_q <= sl_d;
    end
  end
endmodule

// File: tb/tb_fft_power_averager.sv
// tb_fft_power_averager: directed + randomized checks of fft_power_averager at N=8, F=4
module tb_fft_power_averager;
  localparam int N = 8;
  localparam int F = 4;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic s_tvalid = 1'b0;
  logic s_tlast = 1'b0;
  logic s_tready;
  logic [31:0] m_tdata;
  logic m_tvalid;
  logic m_tready = 1'b0;
  logic m_tlast;
  logic frame_error;
  int total = 0;
  int bad = 0;
  int fre[F][N];
  int fim[F][N];
  always #5 aclk = ~aclk;
  fft_power_averager #(.AXIS_TDATA_WIDTH(16), .FFT_LENGTH_LOG(3), .AVG_COUNT_LOG(2)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .S_AXIS_fft_tdata(s_tdata),
    .S_AXIS_fft_tvalid(s_tvalid),
    .S_AXIS_fft_tready(s_tready),
    .S_AXIS_fft_tlast(s_tlast),
    .M_AXIS_power_tdata(m_tdata),
    .M_AXIS_power_tvalid(m_tvalid),
    .M_AXIS_power_tready(m_tready),
    .M_AXIS_power_tlast(m_tlast),
    .frame_error(frame_error)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // Reference: average over F frames of floor((re^2 + im^2) / 2), then floored by F.
  function automatic logic [63:0] expect_bin(input int b);
    longint s;
    s = 0;
    for (int k = 0; k < F; k++)
      s += (longint'(fre[k][b]) * longint'(fre[k][b]) + longint'(fim[k][b]) * longint'(fim[k][b])) >>> 1;
    return 64'(s / F);
  endfunction
  task automatic fill(input int mode);
    for (int k = 0; k < F; k++)
      for (int b = 0; b < N; b++) begin
        fre[k][b] = mode == 0 ? 3 : mode == 1 ? -32768 : mode == 2 ? b + k : int'($urandom_range(0, 65535)) - 32768;
        fim[k][b] = mode == 0 ? 4 : mode == 1 ? -32768 : mode == 2 ? 0 : int'($urandom_range(0, 65535)) - 32768;
      end
  endtask
  task automatic send_beat(input int re, input int im, input logic last, input int gap);
    int g;
    repeat (gap) @(negedge aclk);
    s_tdata = {im[15:0], re[15:0]};
    s_tvalid = 1'b1;
    s_tlast = last;
    g = 0;
    while (!s_tready && g < 100) begin
      @(negedge aclk);
      g++;
    end
    if (g >= 100) check("input_accept_timeout", 64'(s_tready), 64'(1));
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask
  task automatic send_frame(input int k, input int gapmax);
    for (int b = 0; b < N; b++)
      send_beat(fre[k][b], fim[k][b], b == N - 1, int'($urandom_range(0, gapmax)));
  endtask
  task automatic send_frames(input int gapmax);
    for (int k = 0; k < F; k++) send_frame(k, gapmax);
    check("in_ready_drop_after_last_frame", 64'(s_tready), 64'(0));
  endtask
  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic collect(input int mode, input int stop_at);
    int k, cyc, lat;
    logic held, hl;
    logic [31:0] hd;
    k = 0;
    cyc = 0;
    lat = -1;
    held = 1'b0;
    hl = 1'b0;
    hd = '0;
    while (k < N && cyc < 300) begin
      if (held) begin
        check("stall_valid_held", 64'(m_tvalid), 64'(1));
        check("stall_data_held", 64'(m_tdata), 64'(hd));
        check("stall_last_held", 64'(m_tlast), 64'(hl));
      end
      if (m_tvalid && lat < 0) begin
        lat = cyc;
        check("first_beat_latency_le5", 64'(lat <= 5), 64'(1));
      end
      if (mode == 0 && lat >= 0) check("full_rate_valid", 64'(m_tvalid), 64'(1));
      if (k == stop_at && m_tvalid) return;
      m_tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      held = m_tvalid && !m_tready;
      if (held) begin
        hd = m_tdata;
        hl = m_tlast;
      end
      if (m_tvalid && m_tready) begin
        check("beat_data", 64'(m_tdata), expect_bin(k));
        check("beat_last", 64'(m_tlast), 64'(k == N - 1));
        check("in_ready_low_while_draining", 64'(s_tready), 64'(0));
        k++;
      end
      @(negedge aclk);
      cyc++;
    end
    check("beat_count", 64'(k), 64'(N));
    m_tready = 1'b1;
    check("in_ready_back_after_last_beat", 64'(s_tready), 64'(1));
    repeat (3) begin
      check("no_extra_beat", 64'(m_tvalid), 64'(0));
      @(negedge aclk);
    end
  endtask
  initial begin
    repeat (2) @(negedge aclk);
    check("rst_in_ready", 64'(s_tready), 64'(0));
    check("rst_out_valid", 64'(m_tvalid), 64'(0));
    check("rst_out_last", 64'(m_tlast), 64'(0));
    check("rst_out_data", 64'(m_tdata), 64'(0));
    check("rst_frame_error", 64'(frame_error), 64'(0));
    aresetn = 1'b1;
    #1 check("in_ready_low_before_first_clock", 64'(s_tready), 64'(0));
    @(negedge aclk);
    check("in_ready_after_first_clock", 64'(s_tready), 64'(1));
    fill(0);
    send_frames(0);
    collect(0, -1);
    fill(1);
    send_frames(0);
    collect(0, -1);
    fill(2);
    send_frames(0);
    collect(0, -1);
    fill(0);
    send_frames(2);
    collect(1, -1);
    fill(3);
    send_frame(0, 1);
    for (int b = 0; b < 6; b++) send_beat(fre[1][b], fim[1][b], b == 5, 0);
    check("misaligned_sets_error", 64'(frame_error), 64'(1));
    fill(3);
    for (int k = 0; k < 3; k++) send_frame(k, 1);
    repeat (8) begin
      check("no_output_before_fourth_frame", 64'(m_tvalid), 64'(0));
      @(negedge aclk);
    end
    check("error_sticky", 64'(frame_error), 64'(1));
    send_frame(3, 1);
    check("in_ready_drop_after_realigned_frames", 64'(s_tready), 64'(0));
    collect(2, -1);
    check("error_still_sticky", 64'(frame_error), 64'(1));
    fill(3);
    send_frames(1);
    collect(0, 3);
    #2 aresetn = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(m_tvalid), 64'(0));
    check("async_rst_out_last", 64'(m_tlast), 64'(0));
    check("async_rst_out_data", 64'(m_tdata), 64'(0));
    check("async_rst_in_ready", 64'(s_tready), 64'(0));
    check("async_rst_frame_error", 64'(frame_error), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("in_ready_after_rerelease", 64'(s_tready), 64'(1));
    fill(3);
    send_frames(1);
    collect(1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
